// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// multicycle_control_pkg
// State and instruction-class encodings shared by the multicycle controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_LOAD    = 3'd1,
        CL_STORE   = 3'd2,
        CL_CBZ     = 3'd3,
        CL_CBNZ    = 3'd4,
        CL_B       = 3'd5,
        CL_ILLEGAL = 3'd6
    } opclass_e;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/opclass_decode.sv
// ============================================================================
// opclass_decode
// Maps the 11-bit LEGv8 opcode field onto an instruction class.
// Revision: 1.0
// ============================================================================
`default_nettype none

module opclass_decode
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode_i,
    output opclass_e    opclass_o
);

    always_comb begin
        opclass_o = CL_ILLEGAL;
        casez (opcode_i)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: opclass_o = CL_RTYPE;
            11'b11111000010,
            11'b00111000010,
            11'b01111000010,
            11'b10111000100: opclass_o = CL_LOAD;
            11'b11111000000: opclass_o = CL_STORE;
            11'b10110100???: opclass_o = CL_CBZ;
            11'b10110101???: opclass_o = CL_CBNZ;
            11'b000101?????: opclass_o = CL_B;
            default:         opclass_o = CL_ILLEGAL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// Sequencing FSM for the multicycle LEGv8 datapath with retire counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            opcode,
    input  logic                   zero,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    output logic                   imem_read,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic                   readreg2_control,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src,
    output logic [1:0]             alu_op,
    output logic [2:0]             state,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired
);

    state_e                 state_q, state_d;
    opclass_e               class_q, class_d;
    opclass_e               dec_class;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   retire;

    opclass_decode u_opclass_decode (
        .opcode_i  (opcode),
        .opclass_o (dec_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_ILLEGAL;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        class_d          = class_q;
        retire           = 1'b0;
        imem_read        = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        readreg2_control = 1'b0;
        mem_to_reg       = 1'b0;
        reg_write        = 1'b0;
        alu_src          = 1'b0;
        alu_op           = ALU_OP_MEM;
        halted           = 1'b0;

        // Reset is asynchronous, so every request must drop the moment it rises.
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_read = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    class_d          = dec_class;
                    readreg2_control = (dec_class == CL_STORE) || (dec_class == CL_CBZ) ||
                                       (dec_class == CL_CBNZ);
                    state_d          = (dec_class == CL_ILLEGAL) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    case (class_q)
                        CL_RTYPE: begin
                            alu_op  = ALU_OP_RTYPE;
                            state_d = ST_WB;
                        end
                        CL_LOAD, CL_STORE: begin
                            alu_op  = ALU_OP_MEM;
                            alu_src = 1'b1;
                            state_d = ST_MEM;
                        end
                        CL_CBZ, CL_CBNZ, CL_B: begin
                            alu_op   = ALU_OP_BRANCH;
                            pc_src   = 1'b1;
                            pc_write = (class_q == CL_B) ||
                                       ((class_q == CL_CBZ) && zero) ||
                                       ((class_q == CL_CBNZ) && !zero);
                            retire   = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        default: state_d = ST_HALT;
                    endcase
                end
                ST_MEM: begin
                    if (class_q == CL_LOAD) begin
                        dmem_read = 1'b1;
                    end else begin
                        dmem_write       = 1'b1;
                        readreg2_control = 1'b1;
                    end
                    if (dmem_ready) begin
                        if (class_q == CL_LOAD) begin
                            state_d = ST_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_q == CL_LOAD);
                    retire     = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: state_d = ST_FETCH;
            endcase
        end

        retired_d = retire ? retired_q + COUNT_WIDTH'(1) : retired_q;
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

`default_nettype wire
